// File: rtl/alu_exec_ctrl_pkg.sv
// Shared constants for the execute-stage controller: ALU op codes,
// RISC-V opcodes, branch kinds and the controller FSM encoding.
package alu_exec_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_NOP = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_ctrl_decode.sv
// Pure combinational instruction decode: opcode/funct3/funct7_5 to ALU
// control. Anything not explicitly recognised is flagged illegal.
module alu_exec_ctrl_decode
  import alu_exec_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] aluop,
  output logic       use_imm,
  output logic       is_shift,
  output br_kind_t   br_kind,
  output logic       illegal
);

  // Decode table; defaults describe the illegal case.
  always_comb begin
    aluop    = ALU_NOP;
    use_imm  = 1'b0;
    is_shift = 1'b0;
    br_kind  = BR_NONE;
    illegal  = 1'b1;
    case (opcode)
      OP_R, OP_I: begin
        use_imm = (opcode == OP_I);
        case (funct3)
          3'b000: begin
            // Only the register form distinguishes SUB via funct7_5.
            aluop   = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            illegal = 1'b0;
          end
          3'b111: begin
            aluop   = ALU_AND;
            illegal = 1'b0;
          end
          3'b110: begin
            aluop   = ALU_OR;
            illegal = 1'b0;
          end
          3'b101: begin
            // Arithmetic right shift is not supported by the ALU.
            if (!funct7_5) begin
              aluop    = ALU_SRL;
              is_shift = 1'b1;
              illegal  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == 3'b010) begin
          aluop   = ALU_ADD;
          use_imm = 1'b1;
          illegal = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          aluop   = ALU_SUB;
          br_kind = (funct3 == 3'b000) ? BR_EQ : BR_NE;
          illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute-stage controller. Accepts one instruction slice,
// drives the external ALU for one cycle, captures its result and branch
// outcome, and holds them on the output handshake until consumed.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] X,
  output logic [XLEN-1:0] Y,
  output logic [2:0]      ALUop,
  input  logic [XLEN-1:0] Resultado_ALU,
  input  logic            zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  state_t          state_reg;
  br_kind_t        br_kind_reg;
  logic            ill_reg;

  logic [2:0]      dec_aluop;
  logic            dec_use_imm;
  logic            dec_is_shift;
  br_kind_t        dec_br_kind;
  logic            dec_illegal;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] x_next;
  logic [XLEN-1:0] y_next;

  alu_exec_ctrl_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .aluop    (dec_aluop),
    .use_imm  (dec_use_imm),
    .is_shift (dec_is_shift),
    .br_kind  (dec_br_kind),
    .illegal  (dec_illegal)
  );

  // Operand conditioning: the ALU shifts by all of Y, so shift amounts are
  // masked here; illegal encodings present zero operands.
  always_comb begin
    op_b   = dec_use_imm ? imm : rs2_val;
    x_next = dec_illegal ? '0 : rs1_val;
    if (dec_illegal)
      y_next = '0;
    else if (dec_is_shift)
      y_next = {{(XLEN-SHAMT_W){1'b0}}, op_b[SHAMT_W-1:0]};
    else
      y_next = op_b;
  end

  assign in_ready = (state_reg == S_IDLE);

  // Controller FSM with all outputs registered; reset drops any pending op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      br_kind_reg  <= BR_NONE;
      ill_reg      <= 1'b0;
      X            <= '0;
      Y            <= '0;
      ALUop        <= ALU_AND;
      result       <= '0;
      out_valid    <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            X           <= x_next;
            Y           <= y_next;
            ALUop       <= dec_aluop;
            br_kind_reg <= dec_br_kind;
            ill_reg     <= dec_illegal;
            state_reg   <= S_EXEC;
          end
        end
        S_EXEC: begin
          result       <= ill_reg ? '0 : Resultado_ALU;
          branch_taken <= (br_kind_reg == BR_EQ &&  zero) ||
                          (br_kind_reg == BR_NE && !zero);
          illegal      <= ill_reg;
          out_valid    <= 1'b1;
          state_reg    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomised self-checking bench for alu_exec_ctrl with an external ALU
// model and a specification-level reference model.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] X, Y;
  logic [2:0]  ALUop;
  logic [31:0] Resultado_ALU;
  logic        zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Datapath ALU: shifts by the whole of Y; undefined op gives junk.
  always_comb begin
    case (ALUop)
      3'b000:  Resultado_ALU = X & Y;
      3'b001:  Resultado_ALU = X | Y;
      3'b010:  Resultado_ALU = X + Y;
      3'b011:  Resultado_ALU = X - Y;
      3'b100:  Resultado_ALU = (Y > 32'd31) ? 32'd0 : (X >> Y);
      default: Resultado_ALU = 32'hDEADBEEF;
    endcase
  end
  assign zero = (Resultado_ALU == 32'd0);

  alu_exec_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .X(X), .Y(Y), .ALUop(ALUop), .Resultado_ALU(Resultado_ALU), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction semantics straight from the ISA subset description.
  task automatic ref_model(
    input  logic [6:0] op, input logic [2:0] f3, input logic f7,
    input  logic [31:0] a, input logic [31:0] r2, input logic [31:0] im,
    output logic [2:0] e_op, output logic [31:0] e_x, output logic [31:0] e_y,
    output logic [31:0] e_res, output logic e_br, output logic e_ill);
    logic [31:0] b;
    e_op = 3'b111; e_x = 0; e_y = 0; e_res = 0; e_br = 0; e_ill = 1;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      b = (op == 7'b0110011) ? r2 : im;
      if (f3 == 3'd0) begin
        e_ill = 0; e_x = a; e_y = b;
        if (op == 7'b0110011 && f7) begin e_op = 3'b011; e_res = a - b; end
        else begin e_op = 3'b010; e_res = a + b; end
      end else if (f3 == 3'd7) begin
        e_ill = 0; e_x = a; e_y = b; e_op = 3'b000; e_res = a & b;
      end else if (f3 == 3'd6) begin
        e_ill = 0; e_x = a; e_y = b; e_op = 3'b001; e_res = a | b;
      end else if (f3 == 3'd5 && !f7) begin
        e_ill = 0; e_x = a; e_y = b % 32; e_op = 3'b100; e_res = a >> (b % 32);
      end
    end else if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'd2) begin
      e_ill = 0; e_x = a; e_y = im; e_op = 3'b010; e_res = a + im;
    end else if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) begin
      e_ill = 0; e_x = a; e_y = r2; e_op = 3'b011; e_res = a - r2;
      e_br = (f3 == 3'd0) ? (a == r2) : (a != r2);
    end
  endtask

  // Full handshake of one instruction with a given consumer stall.
  task automatic run_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input int stall);
    logic [2:0] e_op; logic [31:0] e_x, e_y, e_res; logic e_br, e_ill;
    ref_model(op, f3, f7, a, b, im, e_op, e_x, e_y, e_res, e_br, e_ill);
    @(negedge clk);
    chk({name, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1; opcode = op; funct3 = f3; funct7_5 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    @(posedge clk); #1;
    in_valid = 0;
    rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; opcode = $urandom;
    chk({name, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    chk({name, ".ALUop"}, {29'd0, ALUop}, {29'd0, e_op});
    chk({name, ".X"}, X, e_x);
    chk({name, ".Y"}, Y, e_y);
    chk({name, ".out_valid_exec"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, ".result"}, result, e_res);
    chk({name, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, e_br});
    chk({name, ".illegal"}, {31'd0, illegal}, {31'd0, e_ill});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({name, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, ".stall_result"}, result, e_res);
      chk({name, ".stall_X"}, X, e_x);
      chk({name, ".stall_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({name, ".release_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, ".release_in_ready"}, {31'd0, in_ready}, 32'd1);
    $display("op %-8s opc=%b f3=%0d f7=%0d rs1=%h rs2=%h imm=%h -> res=%h br=%0d ill=%0d",
             name, op, f3, f7, a, b, im, result, branch_taken, illegal);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, ".X"}, X, 32'd0);
    chk({name, ".Y"}, Y, 32'd0);
    chk({name, ".ALUop"}, {29'd0, ALUop}, 32'd0);
    chk({name, ".result"}, result, 32'd0);
    chk({name, ".branch_taken"}, {31'd0, branch_taken}, 32'd0);
    chk({name, ".illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] op;
    logic [31:0] a, b;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1110011;
    ops[6] = 7'b0110111;
    reset = 1; in_valid = 0; out_ready = 0; opcode = 0; funct3 = 0;
    funct7_5 = 0; rs1_val = 0; rs2_val = 0; imm = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check_reset_state("reset");

    run_op("add",  7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 0);
    run_op("sub",  7'b0110011, 3'd0, 1'b1, 32'd3, 32'd5, 32'd0, 4);
    run_op("srli", 7'b0010011, 3'd5, 1'b0, 32'h80000000, 32'd0, 32'h21, 0);
    run_op("beq",  7'b1100011, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 0);
    run_op("bne_e", 7'b1100011, 3'd1, 1'b0, 32'd9, 32'd9, 32'd0, 0);
    run_op("bne_n", 7'b1100011, 3'd1, 1'b0, 32'd1, 32'd2, 32'd0, 1);
    run_op("ill",  7'b1110011, 3'd0, 1'b0, 32'd4, 32'd6, 32'd8, 0);
    run_op("add2", 7'b0110011, 3'd0, 1'b0, 32'd100, 32'd23, 32'd0, 0);
    run_op("sra",  7'b0110011, 3'd5, 1'b1, 32'hF0, 32'd4, 32'd0, 0);
    run_op("lw",   7'b0000011, 3'd2, 1'b0, 32'h1000, 32'd0, 32'hFFFFFFFC, 0);

    // Reset while in EXEC drops the instruction.
    @(negedge clk);
    in_valid = 1; opcode = 7'b0110011; funct3 = 0; funct7_5 = 0;
    rs1_val = 32'd11; rs2_val = 32'd22;
    @(posedge clk); #1;
    in_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check_reset_state("rst_exec");
    @(posedge clk); #1;
    chk("rst_exec.no_valid", {31'd0, out_valid}, 32'd0);
    $display("op rst_exec dropped pending ADD");

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op("rand", op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             a, b, $urandom, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
